arb_mux_nx1: RTL and testbench

Parametrised N-input, WIDTH-bit arbitrating multiplexer with valid/ready handshakes and a registered output stage. Successor to the 2:1 16-bit datapath mux; it serves the processor's shared-bus paths (e.g. register-file write-back, memory port sharing) where several sources contend for one sink. Channel selection is by round-robin or fixed-priority arbitration, chosen at run time, and the winning word is held until the sink accepts it.

---
 rtl/arb_mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/arb_mux_nx1.sv | 68 ++++++
 tb/tb_arb_mux_nx1.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared constants for the N:1 arbitrating multiplexer.
package arb_mux_pkg;

  localparam logic        MODE_RR    = 1'b0;
  localparam logic        MODE_FIXED = 1'b1;
  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_N      = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin after a pointer, or fixed lowest-index priority.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int unsigned N    = DEF_N,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  input  logic            i_mode,
  output logic [N-1:0]    o_grant,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);

  logic [SELW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    o_any   = |i_req;
    // Scan from the lowest-preference candidate up so the preferred one is assigned last.
    if (i_mode == MODE_FIXED) begin
      for (int unsigned i = N; i >= 1; i--) begin
        w_cand = SELW'(i - 1);
        if (i_req[w_cand]) o_idx = w_cand;
      end
    end else begin
      for (int unsigned k = N; k >= 1; k--) begin
        w_cand = SELW'((32'(i_ptr) + k) % N);
        if (i_req[w_cand]) o_idx = w_cand;
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/arb_mux_nx1.sv
// N-input arbitrating multiplexer with valid/ready handshakes and a registered output word.
module arb_mux_nx1
  import arb_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned N     = DEF_N,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_idx;
  logic             w_any;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .i_mode  (mode),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_load = !r_out_valid || out_ready;
  // The register is already cleared while rst is high, so gate explicitly to keep grants off.
  assign in_ready = w_grant & {N{w_load && !rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= SELW'(N - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_idx*WIDTH +: WIDTH];
        r_out_sel   <= w_idx;
        r_ptr       <= w_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Randomized and directed checks of arb_mux_nx1 against a behavioural model.
module tb_arb_mux_nx1;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 4;
  localparam int unsigned SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  arb_mux_nx1 #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state
  bit          m_valid;
  int unsigned m_data;
  int unsigned m_sel;
  int unsigned m_ptr;
  logic [N-1:0] last_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_sel   = 0;
    m_ptr   = N - 1;
  endtask

  function automatic int model_grant();
    if (mode) begin
      for (int i = 0; i < N; i++) if (in_valid[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (in_valid[c]) return c;
      end
    end
    return -1;
  endfunction

  // One clock: check combinational ready mid-cycle, then the registered result just after the edge.
  task automatic tick();
    int g;
    logic [N-1:0] er;
    bit ld;
    g  = model_grant();
    ld = !m_valid || out_ready;
    er = '0;
    if (ld && g >= 0) er[g] = 1'b1;
    @(negedge clk);
    chk("in_ready", {28'd0, in_ready}, {28'd0, er});
    last_rdy = er;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_sel   = g;
        m_ptr   = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_data", {16'd0, out_data}, m_data);
    chk("out_sel", {30'd0, out_sel}, m_sel);
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b1;
    last_rdy  = '0;
    for (int i = 0; i < N; i++) set_data(i, 16'hA000 + 16'(i));
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'h0000);
    chk("rst_sel", {30'd0, out_sel}, 32'd0);
    chk("rst_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin fairness with all channels requesting
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_seq_sel", {30'd0, out_sel}, k % 4);
      chk("rr_seq_data", {16'd0, out_data}, 32'hA000 + (k % 4));
    end

    // Fixed priority starves channel 3
    mode = 1'b1;
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fixed_sel", {30'd0, out_sel}, 32'd1);
    end

    // Back-pressure holds the word and withholds ready
    in_valid = 4'b0001;
    set_data(0, 16'h0F0F);
    tick();
    chk("bp_load", {16'd0, out_data}, 32'h0F0F);
    in_valid = 4'b0100;
    set_data(2, 16'h2222);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold", {16'd0, out_data}, 32'h0F0F);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_data", {16'd0, out_data}, 32'h2222);
    chk("bp_release_sel", {30'd0, out_sel}, 32'd2);

    // Wrap-around and single requester
    mode = 1'b0;
    in_valid = 4'b1000;
    tick();
    chk("wrap_first", {30'd0, out_sel}, 32'd3);
    tick();
    chk("single_again", {30'd0, out_sel}, 32'd3);
    in_valid = 4'b1001;
    tick();
    chk("wrap_to_0", {30'd0, out_sel}, 32'd0);

    // Randomized traffic; a requester keeps its word until it sees ready
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(in_valid[i] && !last_rdy[i])) begin
          in_valid[i] = ($urandom_range(0, 1) == 1);
          set_data(i, 16'($urandom_range(0, 65535)));
        end
      end
      mode      = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    // Async reset mid-stream
    mode = 1'b0;
    out_ready = 1'b1;
    in_valid = 4'b0110;
    tick();
    chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {28'd0, in_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = '1;
    tick();
    chk("post_arst_sel", {30'd0, out_sel}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
